// File: rtl/cmt_prog_pkg.sv
// cmt_prog_pkg: shared states, command codes and frame length for the DCM_CLKGEN programmer.
package cmt_prog_pkg;
  localparam int FRAME_LEN = 10;
  localparam logic [1:0] CMD_LOADD = 2'b01;
  localparam logic [1:0] CMD_LOADM = 2'b11;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_D,
    ST_GAP1,
    ST_LOAD_M,
    ST_GAP2,
    ST_GO,
    ST_WAIT_DONE
  } state_t;
endpackage

// File: rtl/cmt_prog_shifter.sv
// cmt_prog_shifter: loads a command frame and shifts it out LSB first, flagging the final bit.
module cmt_prog_shifter
  import cmt_prog_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic [FRAME_LEN-1:0] frame_i,
  input  logic                 en_i,
  output logic                 bit_o,
  output logic                 last_o
);
  logic [FRAME_LEN-1:0] sh_q;
  logic [3:0]           cnt_q;
  // load wins over shift; every enabled cycle retires one bit
  always_ff @(posedge clk)
    if (!rst_n) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      sh_q  <= frame_i;
      cnt_q <= '0;
    end else if (en_i) begin
      sh_q  <= sh_q >> 1;
      cnt_q <= cnt_q + 4'd1;
    end
  assign bit_o  = sh_q[0];
  assign last_o = cnt_q == 4'(FRAME_LEN - 1);
endmodule

// File: rtl/cmt_prog_ctrl.sv
// cmt_prog_ctrl: serialises LoadD/LoadM/GO onto progen/progdata and waits for progdone_inv.
// Define CMT_PROG_CTRL_TIMEOUT_EN to abort WAIT_DONE with err after TIMEOUT_CYCLES cycles.
module cmt_prog_ctrl
  import cmt_prog_pkg::*;
#(
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int MIN_WAIT       = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [7:0] req_m,
  input  logic [7:0] req_d,
  output logic       req_ready,
  output logic       progen,
  output logic       progdata,
  input  logic       progdone_inv,
  output logic       busy,
  output logic       done,
  output logic       err
);
  state_t               state_q, state_d;
  logic [7:0]           m_q, m_d, d_q, d_d;
  logic                 err_q, err_d;
  logic [15:0]          cnt_q, cnt_d;
  logic                 sh_load, sh_en, sh_bit, sh_last;
  logic [FRAME_LEN-1:0] sh_frame;

  cmt_prog_shifter u_shifter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (sh_load),
    .frame_i(sh_frame),
    .en_i   (sh_en),
    .bit_o  (sh_bit),
    .last_o (sh_last)
  );

  // state, latched codes, sticky error and the shared gap/wait counter
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      m_q     <= '0;
      d_q     <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      d_q     <= d_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end

  // sequencing: the wait counter stops at TIMEOUT_CYCLES so it never wraps back under MIN_WAIT
  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    d_d      = d_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    sh_load  = 1'b0;
    sh_en    = 1'b0;
    sh_frame = {m_q, CMD_LOADM};
    done     = 1'b0;
    case (state_q)
      ST_IDLE: if (req_valid) begin
        m_d      = req_m;
        d_d      = req_d;
        err_d    = req_m == 8'd0;
        sh_frame = {req_d, CMD_LOADD};
        sh_load  = req_m != 8'd0;
        state_d  = req_m != 8'd0 ? ST_LOAD_D : ST_IDLE;
      end
      ST_LOAD_D, ST_LOAD_M: begin
        sh_en = 1'b1;
        cnt_d = '0;
        if (sh_last) state_d = state_q == ST_LOAD_D ? ST_GAP1 : ST_GAP2;
      end
      ST_GAP1, ST_GAP2: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == 16'(GAP_CYCLES - 1)) begin
          state_d = state_q == ST_GAP1 ? ST_LOAD_M : ST_GO;
          sh_load = state_q == ST_GAP1;
        end
      end
      ST_GO: begin
        cnt_d   = '0;
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        cnt_d = cnt_q == 16'(TIMEOUT_CYCLES) ? cnt_q : cnt_q + 16'd1;
        if (cnt_q >= 16'(MIN_WAIT) && !progdone_inv) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
`ifdef CMT_PROG_CTRL_TIMEOUT_EN
        else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ready = state_q == ST_IDLE;
  assign busy      = state_q != ST_IDLE;
  assign progen    = state_q inside {ST_LOAD_D, ST_LOAD_M, ST_GO};
  assign progdata  = (state_q inside {ST_LOAD_D, ST_LOAD_M}) & sh_bit;
  assign err       = err_q;
endmodule

// File: tb/tb_cmt_prog_ctrl.sv
// tb_cmt_prog_ctrl: random and directed stimulus checked against a frame-queue model of the programmer.
module tb_cmt_prog_ctrl;
  localparam int GAP = 2, MW = 2, TO = 100;
  logic clk = 0, rst_n = 0, req_valid = 0, progdone_inv = 1;
  logic [7:0] req_m = 0, req_d = 0;
  logic req_ready, progen, progdata, busy, done, err;
  int checks = 0, errors = 0;
  logic [1:0] exp_q[$];
  bit waiting = 0, err_m = 0, chk_on = 0;
  int k = 0;
  logic s_pe, s_pd, s_done, s_rdy, s_busy, s_err;

  cmt_prog_ctrl #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO), .MIN_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_m(req_m), .req_d(req_d),
    .req_ready(req_ready), .progen(progen), .progdata(progdata),
    .progdone_inv(progdone_inv), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic build(logic [7:0] m, logic [7:0] d);
    exp_q.push_back(2'b11); exp_q.push_back(2'b10);
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, d[i]});
    repeat (GAP) exp_q.push_back(2'b00);
    exp_q.push_back(2'b11); exp_q.push_back(2'b11);
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, m[i]});
    repeat (GAP) exp_q.push_back(2'b00);
    exp_q.push_back(2'b10);
  endtask

  task automatic compare();
    logic [1:0] cur;
    bit b;
    cur = exp_q.size() != 0 ? exp_q[0] : 2'b00;
    b = exp_q.size() != 0 || waiting;
    chk("progen", progen, cur[1]);
    chk("progdata", progdata, cur[0]);
    chk("busy", busy, b);
    chk("req_ready", req_ready, !b);
    chk("done", done, waiting && k >= MW && !progdone_inv);
    chk("err", err, err_m);
  endtask

  task automatic model_next();
    if (!rst_n) begin
      exp_q.delete();
      waiting = 0;
      err_m = 0;
    end else if (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      if (exp_q.size() == 0) begin
        waiting = 1;
        k = 0;
      end
    end else if (waiting) begin
      if (k >= MW && !progdone_inv) waiting = 0;
`ifdef CMT_PROG_CTRL_TIMEOUT_EN
      else if (k == TO - 1) begin
        waiting = 0;
        err_m = 1;
      end
`endif
      else k++;
    end else if (req_valid) begin
      err_m = req_m == 0;
      if (req_m != 0) build(req_m, req_d);
    end
  endtask

  task automatic step();
    @(negedge clk);
    s_pe = progen; s_pd = progdata; s_done = done; s_rdy = req_ready; s_busy = busy; s_err = err;
    if (chk_on) compare();
    model_next();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    req_valid = 0; progdone_inv = 0; rst_n = 1;
    do begin step(); n++; end while (s_busy && n < 60);
    chk("drain_idle", s_busy, 0);
  endtask

  initial begin
    logic [9:0] cap_d, cap_m;
    int done_cnt, done_at, pe_cnt;
    logic rdy_after;
    step();
    chk_on = 1;
    step();
    rst_n = 1;
    step();

    // M=20, D=27 with progdone_inv dropping 5 cycles after GO
    req_m = 8'h13; req_d = 8'h1A; req_valid = 1; progdone_inv = 1;
    step();
    done_cnt = 0; done_at = 0; pe_cnt = 0; rdy_after = 0;
    for (int i = 1; i < 40; i++) begin
      req_valid = 0;
      progdone_inv = i >= 30 ? 1'b0 : 1'b1;
      step();
      if (i >= 1 && i <= 10) cap_d[i-1] = s_pd;
      if (i >= 13 && i <= 22) cap_m[i-13] = s_pd;
      if (i == 11 || i == 12 || i == 23 || i == 24) pe_cnt += s_pe;
      if (i == 25) chk("go_cycle", {s_pe, s_pd}, 2'b10);
      if (s_done) begin done_cnt++; done_at = i; end
      if (i == 31) rdy_after = s_rdy;
    end
    chk("loadd_stream", cap_d, 10'b0001101001);
    chk("loadm_stream", cap_m, 10'b0001001111);
    chk("gap_progen", pe_cnt, 0);
    chk("done_count", done_cnt, 1);
    chk("done_cycle", done_at, 30);
    chk("ready_after_done", rdy_after, 1);
    drain();

    // illegal M code, then a legal request clears err
    req_valid = 1; req_m = 0; req_d = 8'h44;
    step();
    req_valid = 0; pe_cnt = 0;
    repeat (30) begin step(); pe_cnt += s_pe; end
    chk("reject_progen", pe_cnt, 0);
    chk("reject_err", s_err, 1);
    req_valid = 1; req_m = 8'h05; req_d = 8'h02;
    step();
    req_valid = 0;
    step();
    chk("err_cleared", s_err, 0);
    drain();

    // requests held during busy are ignored
    req_valid = 1; req_m = 8'h21; req_d = 8'h07; progdone_inv = 1;
    step();
    repeat (40) begin
      req_m = 8'($urandom_range(1, 255)); req_d = 8'($urandom);
      step();
    end
    drain();

    // reset during LOAD_M bit 5, then a fresh complete request
    req_valid = 1; req_m = 8'h3C; req_d = 8'h11; progdone_inv = 1;
    step();
    req_valid = 0;
    for (int i = 1; i <= 17; i++) step();
    rst_n = 0;
    step();
    chk("bit5_progen", s_pe, 1);
    rst_n = 1;
    step();
    chk("rst_progen", s_pe, 0);
    chk("rst_busy", s_busy, 0);
    chk("rst_ready", s_rdy, 1);
    req_valid = 1; req_m = 8'h3C; req_d = 8'h11;
    step();
    req_valid = 0;
    repeat (30) step();
    drain();

    // progdone_inv already low at GO: done exactly MIN_WAIT+1 cycles after GO
    req_valid = 1; req_m = 8'($urandom_range(1, 255)); req_d = 8'($urandom); progdone_inv = 0;
    step();
    done_at = 0;
    for (int i = 1; i < 40; i++) begin
      req_valid = 0;
      step();
      if (s_done && done_at == 0) done_at = i;
    end
    chk("early_done_cycle", done_at, 25 + MW + 1);

`ifdef CMT_PROG_CTRL_TIMEOUT_EN
    req_valid = 1; req_m = 8'h13; req_d = 8'h1A; progdone_inv = 1;
    step();
    req_valid = 0; done_cnt = 0;
    repeat (25 + TO + 5) begin step(); done_cnt += s_done; end
    chk("timeout_no_done", done_cnt, 0);
    chk("timeout_err", s_err, 1);
    chk("timeout_idle", s_rdy, 1);
    drain();
`endif

    // random traffic
    repeat (4000) begin
      req_valid = $urandom_range(0, 3) == 0;
      req_m = $urandom_range(0, 7) == 0 ? 8'h00 : 8'($urandom);
      req_d = 8'($urandom);
      progdone_inv = $urandom_range(0, 2) != 0;
      rst_n = $urandom_range(0, 199) != 0;
      step();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
